multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I main decoder.
- A registered FSM sequences each instruction over 3–5 states. One shared memory port is used for fetch and for data, with a ready handshake and a watchdog timeout.
- Drives all datapath enables, including the PC, IR, register file and memory.
- Counts retired instructions and traps on illegal opcodes or memory timeout.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 16, maximum wait cycles for mem_ready per access. 0 disables the watchdog.
- TO_W, 5, width of the wait counter. Must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the IR; sampled in DECODE only
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load the IR
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if the ALU zero flag is set (branch)
- pc_source  out  1  PC source: 0 = ALU result, 1 = ALUOut
- alu_src_a  out  1  ALU input A: 0 = PC, 1 = rs1
- alu_src_b  out  2  ALU input B: 00 = rs2, 01 = const 4, 10 = imm
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
- wb_sel  out  2  write-back select: 00 = ALU, 01 = memory, 10 = PC+4
- reg_write  out  1  register-file write enable
- trap  out  1  sticky error flag
- state_o  out  4  current state encoding, for debug
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (asynchronous, rst_n=0): state = FETCH; opcode_q = 0; wait counter = 0; instret = 0; trap = 0.
- Outputs are a Moore decode of state, except ir_write and pc_write in FETCH, which are gated by mem_ready. Any strobe not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, ADDR=2, MEM_RD=3, MEM_WR=4, WB_MEM=5, EXEC=6, WB_ALU=7, BRANCH=8, JUMP=9, JALR_A=10, TRAP=15.
- FETCH:
  - Outputs: mem_req = mem_read = 1; iord = 0; alu_src_a = 0; alu_src_b = 01; alu_op = 00.
  - When mem_ready = 1: ir_write = 1, pc_write = 1, next state DECODE.
  - Otherwise hold in FETCH.
- DECODE:
  - Outputs: alu_src_a = 0; alu_src_b = 10; alu_op = 00 (branch target into ALUOut). Latch opcode_q.
  - 0110011 or 0010011 → EXEC.
  - 0000011 or 0100011 → ADDR.
  - 1100011 → BRANCH.
  - Any other opcode → TRAP.
- ADDR:
  - Outputs: alu_src_a = 1; alu_src_b = 10; alu_op = 00.
  - Next state: MEM_RD for a load, MEM_WR for a store.
- MEM_RD:
  - Outputs: mem_req = mem_read = 1; iord = 1.
  - Wait for mem_ready, then → WB_MEM.
- MEM_WR:
  - Outputs: mem_req = mem_write = 1; iord = 1.
  - Wait for mem_ready, then → FETCH and retire.
- WB_MEM: reg_write = 1; wb_sel = 01; → FETCH and retire.
- EXEC:
  - Outputs: alu_src_a = 1; alu_op = 10; alu_src_b = 00 for R-type, 10 for I-type.
  - Next state WB_ALU.
- WB_ALU: reg_write = 1; wb_sel = 00; → FETCH and retire.
- BRANCH:
  - Outputs: alu_src_a = 1; alu_src_b = 00; alu_op = 01; pc_write_cond = 1; pc_source = 1.
  - → FETCH and retire.
- TRAP: trap = 1, all enables 0. Absorbing; exits only via reset.
- Retire: instret increments by 1 on the transition into FETCH from a completing state. It wraps modulo 2^CNT_W.
- Latency with zero-wait memory (mem_ready high on the first cycle):
  - branch: 3 cycles
  - R-type, I-type and store: 4 cycles
  - load: 5 cycles
- Watchdog:
  - The wait counter clears on entry to any memory state and increments each cycle mem_ready = 0.
  - If the counter equals MEM_TIMEOUT with mem_ready = 0 → TRAP.
  - If mem_ready = 1 in that same cycle, the access completes normally; ready wins.
- Reset asserted mid-access: the FSM returns to FETCH immediately, and mem_req drops asynchronously.
- Opcode changes outside DECODE are ignored.

Optional Feature:
- Macro: CTRL_JUMP_EN.
- Defined:
  - DECODE sends 1101111 (JAL) → JUMP and 1100111 (JALR) → JALR_A.
  - JALR_A: alu_src_a = 1; alu_src_b = 10; alu_op = 00; → JUMP.
  - JUMP: pc_write = 1; pc_source = 1; reg_write = 1; wb_sel = 10; → FETCH and retire.
  - JAL takes 3 cycles; JALR takes 4.
- Undefined: both opcodes → TRAP. State codes 9 and 10 are unreachable.

Test Plan:
- 1. Reset, mem_ready tied 1, feed opcode 0110011 → states 0,1,6,7,0; reg_write = 1 only in state 7; instret = 1 after 4 cycles.
- 2. Load 0000011 with mem_ready low for 3 cycles in MEM_RD → MEM_RD held 4 cycles; wb_sel = 01 in WB_MEM; total 8 cycles; instret + 1.
- 3. Store 0100011 then branch 1100011 → mem_write = 1 only in MEM_WR; pc_write_cond = 1 only in BRANCH; instret = 2 after 7 cycles.
- 4. Opcode 1111111 → TRAP after DECODE; trap = 1 and all enables 0 for 20 further cycles; rst_n pulse returns to FETCH with trap = 0.
- 5. mem_ready held 0 in FETCH with MEM_TIMEOUT = 16 → TRAP entered on cycle 17. Repeat with mem_ready = 1 exactly on cycle 17 → DECODE, no trap.
- 6. With CTRL_JUMP_EN defined, JAL: states 0,1,9,0 with wb_sel = 10 and pc_write = 1 in JUMP. Without the macro, the same opcode → trap = 1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: one shared memory port for fetch and data
// with a ready handshake and a watchdog, retired-instruction counter, and a
// sticky trap on illegal opcodes or memory timeout.
// Optional feature macro: CTRL_JUMP_EN adds JAL/JALR sequencing (JUMP, JALR_A).
//
// state  | meaning
// FETCH  | read instruction at PC; on mem_ready load IR and PC+4
// DECODE | latch opcode, ALUOut <= branch target, dispatch
// ADDR   | ALUOut <= rs1 + imm (load/store address)
// MEM_RD | data read at ALUOut, wait for mem_ready
// MEM_WR | data write at ALUOut, wait for mem_ready, retire
// WB_MEM | register file <= memory data, retire
// EXEC   | ALU operation (R-type or I-type)
// WB_ALU | register file <= ALU result, retire
// BRANCH | compare rs1/rs2, PC <= ALUOut if zero, retire
// JUMP   | PC <= ALUOut, rd <= PC+4, retire (CTRL_JUMP_EN)
// JALR_A | ALUOut <= rs1 + imm (CTRL_JUMP_EN)
// TRAP   | illegal opcode or timeout; absorbing until reset
module multicycle_control_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic             reg_write,
  output logic             trap,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_MEM = 4'd5,
    S_EXEC   = 4'd6,
    S_WB_ALU = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_JALR_A = 4'd10,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
`ifdef CTRL_JUMP_EN
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
`endif
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [6:0]        opcode_q;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q;
  logic              in_mem, wd_hit, retire;
  logic              req_s, rd_s, wr_s;

  assign in_mem = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // Ready wins: the timeout only fires when the limit is reached without ready.
  assign wd_hit = (MEM_TIMEOUT != 0) && (wait_q == TO_LIM) && !mem_ready;
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
                else if (wd_hit) state_d = S_TRAP;
      S_DECODE: begin
        case (opcode)
          OP_R, OP_I:   state_d = S_EXEC;
          OP_LD, OP_ST: state_d = S_ADDR;
          OP_BR:        state_d = S_BRANCH;
`ifdef CTRL_JUMP_EN
          OP_JAL:       state_d = S_JUMP;
          OP_JALR:      state_d = S_JALR_A;
`endif
          default:      state_d = S_TRAP;
        endcase
      end
      S_ADDR:   state_d = (opcode_q == OP_LD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
                else if (wd_hit) state_d = S_TRAP;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
                else if (wd_hit) state_d = S_TRAP;
      S_WB_MEM: state_d = S_FETCH;
      S_EXEC:   state_d = S_WB_ALU;
      S_WB_ALU: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
`ifdef CTRL_JUMP_EN
      S_JALR_A: state_d = S_JUMP;
      S_JUMP:   state_d = S_FETCH;
`endif
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // Wait counter restarts on every state change and saturates if the watchdog is off.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = '0;
    else if (in_mem && !mem_ready && (wait_q != {TO_W{1'b1}}))
      wait_d = wait_q + TO_W'(1);
  end

  // State, latched opcode, wait counter and retired-instruction count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) opcode_q <= opcode;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Moore decode of the datapath controls; only the FETCH IR/PC loads follow mem_ready.
  always_comb begin
    req_s = 1'b0; rd_s = 1'b0; wr_s = 1'b0; iord = 1'b0;
    ir_write = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0; pc_source = 1'b0;
    alu_src_a = 1'b0; alu_src_b = 2'b00; alu_op = 2'b00; wb_sel = 2'b00;
    reg_write = 1'b0; trap = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_s = 1'b1; rd_s = 1'b1; alu_src_b = 2'b01;
        ir_write = mem_ready; pc_write = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b10;
      S_ADDR:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEM_RD: begin req_s = 1'b1; rd_s = 1'b1; iord = 1'b1; end
      S_MEM_WR: begin req_s = 1'b1; wr_s = 1'b1; iord = 1'b1; end
      S_WB_MEM: begin reg_write = 1'b1; wb_sel = 2'b01; end
      S_EXEC: begin
        alu_src_a = 1'b1; alu_op = 2'b10;
        alu_src_b = (opcode_q == OP_R) ? 2'b00 : 2'b10;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1; alu_op = 2'b01; pc_write_cond = 1'b1; pc_source = 1'b1;
      end
`ifdef CTRL_JUMP_EN
      S_JALR_A: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_JUMP: begin
        pc_write = 1'b1; pc_source = 1'b1; reg_write = 1'b1; wb_sel = 2'b10;
      end
`endif
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

  // Memory strobes fall the moment reset is asserted, not at the next edge.
  assign mem_req   = req_s & rst_n;
  assign mem_read  = rd_s & rst_n;
  assign mem_write = wr_s & rst_n;
  assign state_o   = state_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: each instruction is expanded into its
// expected per-cycle state trace from its class and memory wait counts, then
// replayed cycle by cycle against the DUT.
module tb_multicycle_control_unit;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       opcode = '0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_read, mem_write, iord, ir_write, pc_write;
  logic             pc_write_cond, pc_source, alu_src_a, reg_write, trap;
  logic [1:0]       alu_src_b, alu_op, wb_sel;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instret;

  multicycle_control_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .wb_sel(wb_sel), .reg_write(reg_write), .trap(trap),
    .state_o(state_o), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] st; logic rdy; } step_t;
  step_t plan[$];

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_JALR = 6, C_ILL = 7;
  logic [6:0] ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b1101111, 7'b1100111, 7'b1111111};

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int model_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected control word for a state, from the per-state output table.
  function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic rdy, input logic is_r);
    logic mreq = 0, mrd = 0, mwr = 0, io = 0, irw = 0, pcw = 0, pcc = 0, pcs = 0;
    logic asa = 0, rw = 0, tr = 0;
    logic [1:0] asb = 0, aop = 0, wbs = 0;
    case (st)
      4'd0:  begin mreq = 1; mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  asb = 2'b10;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mreq = 1; mrd = 1; io = 1; end
      4'd4:  begin mreq = 1; mwr = 1; io = 1; end
      4'd5:  begin rw = 1; wbs = 2'b01; end
      4'd6:  begin asa = 1; aop = 2'b10; asb = is_r ? 2'b00 : 2'b10; end
      4'd7:  rw = 1;
      4'd8:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = 1; end
      4'd9:  begin pcw = 1; pcs = 1; rw = 1; wbs = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd15: tr = 1;
      default: tr = 0;
    endcase
    return {mreq, mrd, mwr, io, irw, pcw, pcc, pcs, asa, asb, aop, wbs, rw, tr};
  endfunction

  function automatic logic [16:0] act_ctl();
    return {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
            pc_source, alu_src_a, alu_src_b, alu_op, wb_sel, reg_write, trap};
  endfunction

  task automatic push(input int st, input logic rdy);
    plan.push_back({4'(st), rdy});
  endtask

  // Expected trace of one instruction: fw fetch waits, mw data waits.
  task automatic build(input int cls, input int fw, input int mw, output bit retires);
    plan.delete();
    retires = 1'b1;
    for (int i = 0; i < fw; i++) push(0, 1'b0);
    push(0, 1'b1);
    push(1, 1'($urandom));
    case (cls)
      C_R, C_I: begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
      C_LD: begin
        push(2, 1'($urandom));
        for (int i = 0; i < mw; i++) push(3, 1'b0);
        push(3, 1'b1); push(5, 1'($urandom));
      end
      C_ST: begin
        push(2, 1'($urandom));
        for (int i = 0; i < mw; i++) push(4, 1'b0);
        push(4, 1'b1);
      end
      C_BR: push(8, 1'($urandom));
`ifdef CTRL_JUMP_EN
      C_JAL:  push(9, 1'($urandom));
      C_JALR: begin push(10, 1'($urandom)); push(9, 1'($urandom)); end
`else
      C_JAL, C_JALR: begin push(15, 1'($urandom)); retires = 1'b0; end
`endif
      default: begin push(15, 1'($urandom)); retires = 1'b0; end
    endcase
  endtask

  // Replay up to lim steps; opcode is garbage everywhere except DECODE.
  task automatic run(input logic [6:0] op, input bit is_r, input bit retires, input int lim);
    for (int k = 0; k < plan.size() && k < lim; k++) begin
      @(negedge clk);
      mem_ready = plan[k].rdy;
      opcode = (plan[k].st == 4'd1) ? op : 7'($urandom);
      #1;
      chk("state", 32'(state_o), 32'(plan[k].st));
      chk("ctl", 32'(act_ctl()), 32'(exp_ctl(plan[k].st, plan[k].rdy, is_r)));
      if (k == 0) chk("instret", instret, 32'(model_cnt));
    end
    if (retires && lim >= plan.size()) model_cnt++;
  endtask

  task automatic do_instr(input int cls, input int fw, input int mw);
    bit r;
    build(cls, fw, mw, r);
    run(ops[cls], cls == C_R, r, plan.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_trap", 32'(trap), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_instret", instret, 0);
    model_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit r;
    do_reset();

    // R-type with zero-wait memory: 0,1,6,7 then retire
    do_instr(C_R, 0, 0);
    // load with three wait cycles in MEM_RD
    do_instr(C_LD, 0, 3);
    // store then branch
    do_instr(C_ST, 0, 0);
    do_instr(C_BR, 0, 0);

    // illegal opcode: trap, then 20 cycles of absorbing TRAP
    do_instr(C_ILL, 0, 0);
    plan.delete();
    for (int i = 0; i < 20; i++) push(15, 1'($urandom));
    run(7'h00, 1'b0, 1'b0, plan.size());
    do_reset();

    // fetch timeout: 16 waits are tolerated, the 17th without ready traps
    plan.delete();
    for (int i = 0; i < 17; i++) push(0, 1'b0);
    push(15, 1'b1);
    run(7'h00, 1'b0, 1'b0, plan.size());
    do_reset();
    // ready on that same 17th cycle completes normally
    do_instr(C_I, 16, 0);
    // data-side boundary: 16 waits in MEM_WR still complete
    do_instr(C_ST, 0, 16);

    // reset during a data read: FSM and mem_req drop without a clock edge
    build(C_LD, 0, 5, r);
    run(ops[C_LD], 1'b0, 1'b0, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", 32'(mem_req), 0);
    chk("async_state", 32'(state_o), 0);
    model_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // JAL / JALR: sequenced when the jump feature is built in, trap otherwise
    do_instr(C_JAL, 0, 0);
`ifndef CTRL_JUMP_EN
    do_reset();
`endif
    do_instr(C_JALR, 0, 0);
`ifndef CTRL_JUMP_EN
    do_reset();
`endif

    // randomized legal instruction mix
    for (int n = 0; n < 40; n++) begin
      int cls, fw, mw;
`ifdef CTRL_JUMP_EN
      cls = $urandom_range(0, 6);
`else
      cls = $urandom_range(0, 4);
`endif
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16) : $urandom_range(0, 2);
      do_instr(cls, fw, mw);
    end

    // final idle FETCH cycle to check the last retire
    plan.delete();
    push(0, 1'b0);
    run(7'h00, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
